mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_pkg.sv | 43 ++++
 rtl/mbist_march_ctrl_if.sv | 28 ++
 rtl/mbist_cmp_pipe.sv | 44 ++++
 rtl/mbist_march_ctrl.sv | 149 ++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbist_pkg.sv
// Shared types and per-element March C- tables for the MBIST controller.
package mbist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RD,
    ST_WR,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // March element index, 0..5.
  typedef logic [2:0] elem_t;
  localparam elem_t LAST_ELEM = 3'd5;

  // Operations issued at each address of an element.
  typedef enum logic [1:0] {
    OPK_W,   // write only
    OPK_RW,  // read then write
    OPK_R    // read only
  } op_kind_t;

  typedef struct packed {
    logic     down;    // address sweeps LAST_ADDR..0
    logic     rd_one;  // read expects all-ones
    logic     wr_one;  // write pattern is all-ones
    op_kind_t ops;
  } elem_cfg_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
  function automatic elem_cfg_t elem_cfg(elem_t e);
    case (e)
      3'd0:    elem_cfg = '{down: 1'b0, rd_one: 1'b0, wr_one: 1'b0, ops: OPK_W};
      3'd1:    elem_cfg = '{down: 1'b0, rd_one: 1'b0, wr_one: 1'b1, ops: OPK_RW};
      3'd2:    elem_cfg = '{down: 1'b0, rd_one: 1'b1, wr_one: 1'b0, ops: OPK_RW};
      3'd3:    elem_cfg = '{down: 1'b1, rd_one: 1'b0, wr_one: 1'b1, ops: OPK_RW};
      3'd4:    elem_cfg = '{down: 1'b1, rd_one: 1'b1, wr_one: 1'b0, ops: OPK_RW};
      default: elem_cfg = '{down: 1'b0, rd_one: 1'b0, wr_one: 1'b0, ops: OPK_R};
    endcase
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Memory command bus and test control/status of the MBIST controller.
interface mbist_march_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic                  start;
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [DATA_WIDTH-1:0] fail_data;

  // Controller side.
  modport master (
    input  start, rdata,
    output write_read, address, wdata, busy, done, fail, fail_addr, fail_data
  );

  // Memory and test-host side.
  modport slave (
    output start, rdata,
    input  write_read, address, wdata, busy, done, fail, fail_addr, fail_data
  );
endinterface

// File: rtl/mbist_cmp_pipe.sv
// Two-stage read-tag delay line matching the memory read latency, plus the
// mismatch flag evaluated against returning read data.
module mbist_cmp_pipe #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  issue_vld,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [DATA_WIDTH-1:0] issue_exp,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  mismatch,
  output logic [ADDR_WIDTH-1:0] mis_addr
);

  logic                  vld1_q, vld2_q;
  logic [ADDR_WIDTH-1:0] addr1_q, addr2_q;
  logic [DATA_WIDTH-1:0] exp1_q, exp2_q;

  // Shift read tags two stages; a flush discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      exp1_q  <= '0;
      exp2_q  <= '0;
    end else begin
      vld1_q  <= issue_vld && !flush;
      vld2_q  <= vld1_q && !flush;
      addr1_q <= issue_addr;
      addr2_q <= addr1_q;
      exp1_q  <= issue_exp;
      exp2_q  <= exp1_q;
    end
  end

  assign mismatch = vld2_q && (rdata != exp2_q);
  assign mis_addr = addr2_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller: sequences the six march elements,
// compares read data two cycles after issue and reports the first failure.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned LAST_ADDR  = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  mbist_march_ctrl_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  elem_t                 elem_q;
  elem_cfg_t             cfg;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drain_q;
  logic                  fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_data_q;

  logic                  start_ok;
  logic                  at_end;
  logic                  step;
  logic                  elem_adv;
  state_t                after_elem;
  logic                  issue_vld;
  logic [DATA_WIDTH-1:0] issue_exp;
  logic                  mismatch;
  logic [ADDR_WIDTH-1:0] mis_addr;

  // Next-state, address-step and element-advance decisions.
  always_comb begin
    cfg        = elem_cfg(elem_q);
    start_ok   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    at_end     = cfg.down ? (addr_q == '0) : (addr_q == LAST_A);
    after_elem = (elem_q == LAST_ELEM) ? ST_DRAIN : ST_SETUP;
    state_d    = state_q;
    step       = 1'b0;
    elem_adv   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (start_ok) state_d = ST_SETUP;
      ST_SETUP:         state_d = (cfg.ops == OPK_W) ? ST_WR : ST_RD;
      ST_RD: begin
        if (cfg.ops == OPK_RW) begin
          state_d = ST_WR;
        end else if (at_end) begin
          elem_adv = 1'b1;
          state_d  = after_elem;
        end else begin
          step = 1'b1;
        end
      end
      ST_WR: begin
        if (at_end) begin
          elem_adv = 1'b1;
          state_d  = after_elem;
        end else begin
          step    = 1'b1;
          state_d = (cfg.ops == OPK_W) ? ST_WR : ST_RD;
        end
      end
      ST_DRAIN:         if (drain_q) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
    // A mismatch ends the run from any busy state; nothing further is issued.
    if (mismatch) state_d = ST_DONE;
    issue_vld = (state_q == ST_RD);
    issue_exp = cfg.rd_one ? '1 : '0;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Element index, address and write-pattern registers, drain timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      drain_q <= 1'b0;
    end else begin
      drain_q <= (state_q == ST_DRAIN) && !drain_q;
      if (start_ok) begin
        elem_q <= '0;
      end else if (elem_adv && (elem_q != LAST_ELEM)) begin
        elem_q <= elem_q + 3'd1;
      end
      if (state_q == ST_SETUP) begin
        addr_q  <= cfg.down ? LAST_A : '0;
        wdata_q <= cfg.wr_one ? '1 : '0;
      end else if (step) begin
        addr_q <= cfg.down ? (addr_q - A_ONE) : (addr_q + A_ONE);
      end
    end
  end

  // First-failure capture, cleared when a new run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (start_ok) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (mismatch) begin
      fail_q      <= 1'b1;
      fail_addr_q <= mis_addr;
      fail_data_q <= bus.rdata;
    end
  end

  mbist_cmp_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_cmp_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (mismatch),
    .issue_vld  (issue_vld),
    .issue_addr (addr_q),
    .issue_exp  (issue_exp),
    .rdata      (bus.rdata),
    .mismatch   (mismatch),
    .mis_addr   (mis_addr)
  );

  assign bus.write_read = (state_q == ST_WR);
  assign bus.address    = addr_q;
  assign bus.wdata      = wdata_q;
  assign bus.busy       = (state_q == ST_SETUP) || (state_q == ST_RD) ||
                          (state_q == ST_WR) || (state_q == ST_DRAIN);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.fail       = fail_q;
  assign bus.fail_addr  = fail_addr_q;
  assign bus.fail_data  = fail_data_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: a small (4-word) and a larger (1024-word)
// instance, each with a faultable 2-cycle-latency memory, checked against an
// operation-level March C- model.
module tb_mbist_march_ctrl;

  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int LA_S = 3;
  localparam int LA_B = 1023;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_s ();
  mbist_march_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(LA_S)) u_dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.master)
  );

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAST_ADDR(LA_B)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Fault configuration per memory: mode 0 none, 1 stuck bits, 2 dead cell
  // (writes ignored, reads return a fixed word).
  int          fm [2];
  int          fa [2];
  logic [DW-1:0] f1 [2];
  logic [DW-1:0] f0 [2];
  logic [DW-1:0] fd [2];

  function automatic logic [DW-1:0] cell_read(input int mode, input int faddr, input int a,
                                              input logic [DW-1:0] s1, input logic [DW-1:0] s0,
                                              input logic [DW-1:0] dv, input logic [DW-1:0] stored);
    if (a == faddr && mode == 1) return (stored | s1) & ~s0;
    if (a == faddr && mode == 2) return dv;
    return stored;
  endfunction

  logic [DW-1:0] mem_s [0:LA_S];
  logic [DW-1:0] mem_b [0:LA_B];
  logic [DW-1:0] rq1_s, rq2_s, rq1_b, rq2_b;

  always @(posedge clk) begin
    rq1_s <= cell_read(fm[0], fa[0], int'(bus_s.address[1:0]), f1[0], f0[0], fd[0],
                       mem_s[bus_s.address[1:0]]);
    rq2_s <= rq1_s;
    if (bus_s.write_read && !(fm[0] == 2 && int'(bus_s.address[1:0]) == fa[0]))
      mem_s[bus_s.address[1:0]] <= bus_s.wdata;
  end

  always @(posedge clk) begin
    rq1_b <= cell_read(fm[1], fa[1], int'(bus_b.address[9:0]), f1[1], f0[1], fd[1],
                       mem_b[bus_b.address[9:0]]);
    rq2_b <= rq1_b;
    if (bus_b.write_read && !(fm[1] == 2 && int'(bus_b.address[9:0]) == fa[1]))
      mem_b[bus_b.address[9:0]] <= bus_b.wdata;
  end

  assign bus_s.rdata = rq2_s;
  assign bus_b.rdata = rq2_b;

  // Observation mux over the instance under test.
  int            sel = 0;
  logic          o_busy, o_done, o_fail, o_wr;
  logic [AW-1:0] o_addr, o_faddr;
  logic [DW-1:0] o_wdata, o_fdata;

  always_comb begin
    if (sel == 0) begin
      o_busy = bus_s.busy; o_done = bus_s.done; o_fail = bus_s.fail; o_wr = bus_s.write_read;
      o_addr = bus_s.address; o_faddr = bus_s.fail_addr;
      o_wdata = bus_s.wdata; o_fdata = bus_s.fail_data;
    end else begin
      o_busy = bus_b.busy; o_done = bus_b.done; o_fail = bus_b.fail; o_wr = bus_b.write_read;
      o_addr = bus_b.address; o_faddr = bus_b.fail_addr;
      o_wdata = bus_b.wdata; o_fdata = bus_b.fail_data;
    end
  end

  task automatic drive_start(input int s, input logic v);
    if (s == 0) bus_s.start = v;
    else        bus_b.start = v;
  endtask

  // Reference: one entry per command cycle, cycle 1 = first cycle after start.
  bit            m_wr   [$];
  int            m_addr [$];
  logic [DW-1:0] m_data [$];
  bit            m_chk  [$];
  bit            m_fail;
  int            m_faddr;
  logic [DW-1:0] m_fdata;
  int            m_done;

  task automatic build_model(input int n, input int mode, input int faddr,
                             input logic [DW-1:0] s1, input logic [DW-1:0] s0,
                             input logic [DW-1:0] dv);
    logic [DW-1:0] cells [];
    logic [DW-1:0] v, pat;
    int a, fcyc;
    cells = new[n];
    m_wr.delete(); m_addr.delete(); m_data.delete(); m_chk.delete();
    m_fail = 1'b0; m_faddr = 0; m_fdata = '0; fcyc = 0;
    for (int e = 0; e < 6; e++) begin
      // setup cycle: a read whose address and data are irrelevant
      m_wr.push_back(1'b0); m_addr.push_back(0); m_data.push_back('0); m_chk.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
        a = (e == 3 || e == 4) ? n - 1 - i : i;
        if (e >= 1) begin
          pat = (e == 2 || e == 4) ? '1 : '0;
          m_wr.push_back(1'b0); m_addr.push_back(a); m_data.push_back('0); m_chk.push_back(1'b1);
          v = cell_read(mode, faddr, a, s1, s0, dv, cells[a]);
          if (!m_fail && v !== pat) begin
            m_fail = 1'b1; m_faddr = a; m_fdata = v; fcyc = m_wr.size();
          end
        end
        if (e <= 4) begin
          pat = (e == 1 || e == 3) ? '1 : '0;
          m_wr.push_back(1'b1); m_addr.push_back(a); m_data.push_back(pat); m_chk.push_back(1'b1);
          if (!(mode == 2 && a == faddr)) cells[a] = pat;
        end
      end
    end
    m_done = m_fail ? fcyc + 3 : m_wr.size() + 3;
  endtask

  // Start one run, check every cycle against the model, then final status.
  task automatic run_check(input int s, input string name, input int mode, input int faddr,
                           input logic [DW-1:0] s1, input logic [DW-1:0] s0,
                           input logic [DW-1:0] dv, input int busy_k_in);
    int n, k, errs, first_done, limit, busy_k, sz;
    bit ok, ewr;
    string msg;
    n = (s == 0) ? LA_S + 1 : LA_B + 1;
    sel = s;
    fm[s] = mode; fa[s] = faddr; f1[s] = s1; f0[s] = s0; fd[s] = dv;
    build_model(n, mode, faddr, s1, s0, dv);
    sz = m_wr.size();
    busy_k = (busy_k_in < 0) ? int'($urandom_range(m_done - 1, 1)) : busy_k_in;
    limit = m_done + 3;
    errs = 0; first_done = -1; msg = "";
    @(negedge clk);
    drive_start(s, 1'b1);
    @(negedge clk);
    k = 1;
    while (k <= limit) begin
      if (o_done === 1'b1 && first_done < 0) first_done = k;
      if (k < m_done) begin
        ewr = (k <= sz) ? m_wr[k-1] : 1'b0;
        ok = (o_busy === 1'b1) && (o_done === 1'b0) && (o_fail === 1'b0) &&
             (o_faddr === '0) && (o_fdata === '0) && (o_wr === ewr);
        if (k <= sz && m_chk[k-1] && o_addr !== AW'(m_addr[k-1])) ok = 1'b0;
        if (k <= sz && m_wr[k-1] && o_wdata !== m_data[k-1]) ok = 1'b0;
      end else begin
        ewr = 1'b0;
        ok = (o_busy === 1'b0) && (o_done === 1'b1) && (o_wr === 1'b0);
      end
      if (!ok) begin
        if (errs == 0)
          msg = $sformatf("cycle %0d busy=%b done=%b wr=%b(req %b) addr=%0d wdata=%h fail=%b",
                          k, o_busy, o_done, o_wr, ewr, o_addr, o_wdata, o_fail);
        errs++;
      end
      drive_start(s, (k == busy_k));
      @(negedge clk);
      k++;
    end
    drive_start(s, 1'b0);
    n_cmp++;
    if (errs !== 0) begin
      n_bad++;
      $display("FAIL %s trace: %0d bad cycles, first at %s; required 0 bad cycles", name, errs, msg);
    end
    n_cmp++;
    if (first_done !== m_done) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, first_done, m_done);
    end
    n_cmp++;
    if (o_fail !== m_fail) begin
      n_bad++;
      $display("FAIL %s fail: got %b required %b", name, o_fail, m_fail);
    end
    n_cmp++;
    if (o_faddr !== AW'(m_faddr)) begin
      n_bad++;
      $display("FAIL %s fail_addr: got %0d required %0d", name, o_faddr, m_faddr);
    end
    n_cmp++;
    if (o_fdata !== m_fdata) begin
      n_bad++;
      $display("FAIL %s fail_data: got %h required %h", name, o_fdata, m_fdata);
    end
  endtask

  task automatic check_zero(input string name);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      n_cmp++;
      if ({o_busy, o_done, o_fail, o_wr, o_addr, o_wdata, o_faddr, o_fdata} !== '0) begin
        n_bad++;
        $display("FAIL %s dut%0d outputs: busy=%b done=%b fail=%b wr=%b addr=%h wdata=%h faddr=%h fdata=%h required all zero",
                 name, s, o_busy, o_done, o_fail, o_wr, o_addr, o_wdata, o_faddr, o_fdata);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_march_pass();
    run_check(0, "pass_n4", 0, 0, '0, '0, '0, 0);
  endtask

  task automatic test_stuck_bit();
    run_check(0, "stuck1_a2", 1, 2, 32'h0000_0001, '0, '0, 0);
  endtask

  task automatic test_start_busy();
    run_check(0, "start_busy_c10", 0, 0, '0, '0, '0, 10);
    run_check(0, "start_busy_rand", 0, 0, '0, '0, '0, -1);
  endtask

  task automatic test_reset_mid_run();
    sel = 0;
    @(negedge clk);
    drive_start(0, 1'b1);
    @(negedge clk);
    drive_start(0, 1'b0);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    check_zero("reset_async");
    @(posedge clk);
    @(negedge clk);
    check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    run_check(0, "after_reset", 0, 0, '0, '0, '0, 0);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] s1;
    s1 = $urandom | 32'h1;
    run_check(0, "b2b_fail", 1, int'($urandom_range(LA_S, 0)), s1, '0, '0, 0);
    run_check(0, "b2b_clean", 0, 0, '0, '0, '0, 0);
  endtask

  task automatic test_random_faults();
    int mode, a;
    logic [DW-1:0] s1, s0, dv;
    for (int i = 0; i < 12; i++) begin
      mode = int'($urandom_range(2, 0));
      a    = int'($urandom_range(LA_S, 0));
      s1   = ($urandom_range(1, 0) != 0) ? (DW'(1) << $urandom_range(DW - 1, 0)) : $urandom;
      s0   = $urandom & ~s1;
      dv   = $urandom;
      run_check(0, $sformatf("rand%0d", i), mode, a, s1, s0, dv,
                ($urandom_range(1, 0) != 0) ? -1 : 0);
    end
  endtask

  task automatic test_big_memory();
    run_check(1, "dead_a1000", 2, 1000, '0, '0, 32'h0000_00AB, 0);
    run_check(1, "dead_rand", 2, int'($urandom_range(LA_B, 0)), '0, '0, $urandom, -1);
    run_check(1, "pass_n1024", 0, 0, '0, '0, '0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    for (int s = 0; s < 2; s++) begin
      fm[s] = 0; fa[s] = 0; f1[s] = '0; f0[s] = '0; fd[s] = '0;
    end
    bus_s.start = 1'b0;
    bus_b.start = 1'b0;
    test_reset();
    test_march_pass();
    test_stuck_bit();
    test_start_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random_faults();
    test_big_memory();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
